// File: rtl/pair_entry_if.sv
// pair_entry_if: host/pipeline signal bundle for pair_entry_fifo.
//   host_in    [193:0]  pair record: [96:0] particle A, [193:97] particle B
//   write_ctrl          level-toggled host write strobe (rising edge = push)
//   stall               pipeline back-pressure, sampled at the frame's last slot
//   out        [226:0]  pair bus: [96:0] A, [193:97] B, [194] valid_a,
//                       [195] valid_b, [226:196] dispatch sequence number
//   in_count   [31:0]   FIFO occupancy, zero-extended
//   full                occupancy == DEPTH
//   overflow            sticky: a push was rejected because the FIFO was full
// Handshake: there is no ready/valid pair. A push is offered on each 0->1
// transition of write_ctrl and is either accepted or dropped (overflow flags
// drops caused by a full FIFO). A dispatched record appears on out for
// exactly one cycle and carries its own valid bits; stall is the only
// back-pressure and holds the whole frame.
interface pair_entry_if;
    logic [193:0] host_in;
    logic         write_ctrl;
    logic         stall;
    logic [226:0] out;
    logic [31:0]  in_count;
    logic         full;
    logic         overflow;

    modport master (
        output host_in, write_ctrl, stall,
        input  out, in_count, full, overflow
    );

    modport slave (
        input  host_in, write_ctrl, stall,
        output out, in_count, full, overflow
    );
endinterface

// File: rtl/pair_entry_fifo.sv
// pair_entry_fifo: host-to-pipeline injection buffer for two-particle pair
// records. Records pushed by the host are queued and dispatched at most one
// per FRAME-cycle pipeline frame onto the 227-bit pair bus, in the same
// format as the pair exit bus.
// Ports:
//   clk    clock
//   reset  synchronous, active-high; flushes the FIFO and clears all status
//   bus    pair_entry_if.slave (host_in, write_ctrl, stall in;
//          out, in_count, full, overflow out)
module pair_entry_fifo #(
    parameter int          DEPTH  = 64,
    parameter int          FRAME  = 16,
    parameter logic [96:0] NULL_P = {1'b1, 96'b0}
) (
    input  logic         clk,
    input  logic         reset,
    pair_entry_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FRAME);
    localparam logic [226:0] NULL_OUT = {31'b0, 2'b00, NULL_P, NULL_P};

    logic [193:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic [CW-1:0] frame_cnt;
    logic [30:0]   seq;
    logic          write_ctrl_q;
    logic          full_q, overflow_q;
    logic [226:0]  out_q;

    logic          push_req, both_null, is_full, push_ok, push_drop_full;
    logic          frame_last, pop;
    logic [193:0]  rd_rec;
    logic [96:0]   rd_a, rd_b;

    // Push qualification. Fullness is judged on the registered occupancy,
    // i.e. before any pop in the same cycle, so a push that coincides with a
    // pop from a full FIFO is still dropped.
    always_comb begin
        push_req       = bus.write_ctrl & ~write_ctrl_q;
        both_null      = (bus.host_in[96:0] == NULL_P) && (bus.host_in[193:97] == NULL_P);
        is_full        = (count == (AW+1)'(DEPTH));
        push_ok        = push_req & ~both_null & ~is_full & ~reset;
        push_drop_full = push_req & ~both_null & is_full;
    end

    // Dispatch decision at the last slot of the frame. Occupancy is the
    // pre-push value, so a record pushed in this same cycle waits a frame.
    always_comb begin
        frame_last = (frame_cnt == CW'(FRAME - 1));
        pop        = frame_last & (count != '0) & ~bus.stall;
        rd_rec     = mem[rd_ptr];
        rd_a       = rd_rec[96:0];
        rd_b       = rd_rec[193:97];
    end

    always_comb begin
        count_next = count;
        if (push_ok && !pop)
            count_next = count + (AW+1)'(1);
        else if (!push_ok && pop)
            count_next = count - (AW+1)'(1);
    end

    // Storage has no reset: contents are dead once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= bus.host_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            frame_cnt    <= CW'(FRAME - 1);
            seq          <= '0;
            write_ctrl_q <= 1'b0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            out_q        <= NULL_OUT;
        end else begin
            write_ctrl_q <= bus.write_ctrl;
            frame_cnt    <= frame_last ? '0 : frame_cnt + CW'(1);
            count        <= count_next;
            full_q       <= (count_next == (AW+1)'(DEPTH));
            if (push_drop_full)
                overflow_q <= 1'b1;
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            // out holds a record only in slot 0 of the frame after the pop;
            // every other cycle it reverts to the null value.
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                seq    <= seq + 31'd1;
                out_q  <= {seq, (rd_b != NULL_P), (rd_a != NULL_P), rd_b, rd_a};
            end else begin
                out_q  <= NULL_OUT;
            end
        end
    end

    assign bus.out      = out_q;
    assign bus.in_count = 32'(count);
    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_pair_entry_fifo.sv
module tb_pair_entry_fifo;
    localparam int FRAME = 16;
    localparam logic [96:0]  NULL_P   = {1'b1, 96'b0};
    localparam logic [226:0] NULL_OUT = {31'b0, 2'b00, NULL_P, NULL_P};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pair_entry_if bus ();

    pair_entry_fifo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int           n_vec = 0;
    int           n_bad = 0;
    int           slot  = 0;
    logic [193:0] exp_q[$];
    logic [30:0]  exp_seq;
    int           exp_cnt;

    task automatic check_vec(input string tag, input logic [226:0] obs, input logic [226:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [226:0] mk_out(input logic [193:0] rec, input logic [30:0] s);
        logic [96:0] a;
        logic [96:0] b;
        a = rec[96:0];
        b = rec[193:97];
        return {s, (b != NULL_P), (a != NULL_P), b, a};
    endfunction

    function automatic logic [193:0] mk_rec(input int a, input int b);
        return {97'(b), 97'(a)};
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        slot = (slot + 1) % FRAME;
    endtask

    task automatic goto_slot(input int s);
        for (int i = 0; i < FRAME; i++) begin
            if (slot == s) break;
            tick();
        end
    endtask

    task automatic push(input logic [193:0] rec);
        bus.host_in    = rec;
        bus.write_ctrl = 1'b1;
        tick();
        bus.write_ctrl = 1'b0;
        tick();
    endtask

    task automatic release_reset();
        reset = 1'b0;
        tick();
        slot    = 0;
        exp_seq = '0;
        exp_q.delete();
    endtask

    // Checks the slot-0 output of a frame that should dispatch the queue head.
    task automatic expect_dispatch(input string tag);
        logic [193:0] rec;
        if (exp_q.size() == 0) begin
            check_vec({tag, "_qempty"}, 227'(1), 227'(0));
        end else begin
            rec = exp_q.pop_front();
            check_vec(tag, bus.out, mk_out(rec, exp_seq));
            exp_seq = exp_seq + 31'd1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [193:0] rec;
        reset          = 1'b1;
        bus.host_in    = '0;
        bus.write_ctrl = 1'b0;
        bus.stall      = 1'b0;
        exp_seq        = '0;
        tick();
        tick();
        check_vec("rst_out",      bus.out,              NULL_OUT);
        check_vec("rst_in_count", 227'(bus.in_count),   227'(0));
        check_vec("rst_full",     227'(bus.full),       227'(0));
        check_vec("rst_overflow", 227'(bus.overflow),   227'(0));
        release_reset();

        // 1: single record pushed at cycle 3, dispatched at cycle 16.
        goto_slot(3);
        rec            = mk_rec(5, 7);
        bus.host_in    = rec;
        bus.write_ctrl = 1'b1;
        exp_q.push_back(rec);
        tick();
        check_vec("t1_cnt_up", 227'(bus.in_count), 227'(1));
        bus.write_ctrl = 1'b0;
        goto_slot(0);
        check_vec("t1_out", bus.out, {31'd0, 2'b11, 97'h7, 97'h5});
        exp_q.delete();
        exp_seq = 31'd1;
        check_vec("t1_cnt_dn", 227'(bus.in_count), 227'(0));
        tick();
        check_vec("t1_out_gone", bus.out, NULL_OUT);

        // 2: B null -> valid_b clear; both null -> dropped.
        rec = {NULL_P, 97'h9};
        push(rec);
        exp_q.push_back(rec);
        goto_slot(0);
        check_vec("t2_b_null", bus.out, {31'd1, 2'b01, NULL_P, 97'h9});
        exp_q.delete();
        exp_seq = 31'd2;
        tick();
        push({NULL_P, NULL_P});
        check_vec("t2_rej_cnt", 227'(bus.in_count), 227'(0));
        check_vec("t2_rej_ovf", 227'(bus.overflow), 227'(0));
        goto_slot(0);
        check_vec("t2_rej_out", bus.out, NULL_OUT);

        // 3: held strobe pushes once, then fill to DEPTH under stall.
        bus.stall      = 1'b1;
        rec            = mk_rec(32'h100, 32'h200);
        bus.host_in    = rec;
        bus.write_ctrl = 1'b1;
        exp_q.push_back(rec);
        repeat (40) tick();
        check_vec("t3_hold_once", 227'(bus.in_count), 227'(1));
        bus.write_ctrl = 1'b0;
        tick();
        for (int i = 1; i < 64; i++) begin
            rec = mk_rec(32'h100 + i, 32'h200 + i);
            push(rec);
            exp_q.push_back(rec);
        end
        check_vec("t3_full_cnt", 227'(bus.in_count), 227'(64));
        check_vec("t3_full",     227'(bus.full),     227'(1));
        check_vec("t3_no_ovf",   227'(bus.overflow), 227'(0));
        push(mk_rec(32'h3AA, 32'h3BB));
        check_vec("t3_ovf",      227'(bus.overflow), 227'(1));
        check_vec("t3_ovf_cnt",  227'(bus.in_count), 227'(64));

        // 4: drain in FIFO order; push during the full-FIFO pop is dropped.
        goto_slot(FRAME - 1);
        bus.stall      = 1'b0;
        bus.host_in    = mk_rec(32'h3CC, 32'h3DD);
        bus.write_ctrl = 1'b1;
        tick();
        bus.write_ctrl = 1'b0;
        expect_dispatch("t4_pop0");
        check_vec("t4_cnt0", 227'(bus.in_count), 227'(63));
        check_vec("t4_full_dn", 227'(bus.full), 227'(0));
        tick();
        check_vec("t4_null_after", bus.out, NULL_OUT);
        exp_cnt = 63;
        for (int k = 1; k < 5; k++) begin
            goto_slot(0);
            expect_dispatch("t4_pop");
            exp_cnt--;
            check_vec("t4_cnt", 227'(bus.in_count), 227'(exp_cnt));
            tick();
        end

        // 5: one stalled frame, then contiguous sequence.
        goto_slot(FRAME - 1);
        bus.stall = 1'b1;
        tick();
        check_vec("t5_stalled_out", bus.out, NULL_OUT);
        check_vec("t5_stalled_cnt", 227'(bus.in_count), 227'(exp_cnt));
        bus.stall = 1'b0;
        tick();
        goto_slot(0);
        expect_dispatch("t5_resume");
        exp_cnt--;
        check_vec("t5_cnt", 227'(bus.in_count), 227'(exp_cnt));

        // 6: reset mid-run discards buffered records and sticky overflow.
        goto_slot(5);
        reset = 1'b1;
        tick();
        check_vec("t6_cnt",  227'(bus.in_count), 227'(0));
        check_vec("t6_out",  bus.out,            NULL_OUT);
        check_vec("t6_ovf",  227'(bus.overflow), 227'(0));
        check_vec("t6_full", 227'(bus.full),     227'(0));
        release_reset();
        for (int i = 0; i < 5; i++)
            push(mk_rec(32'h50 + i, 32'h60 + i));
        check_vec("t6_five", 227'(bus.in_count), 227'(5));
        reset = 1'b1;
        tick();
        check_vec("t6_cnt2", 227'(bus.in_count), 227'(0));
        check_vec("t6_out2", bus.out, NULL_OUT);
        release_reset();
        tick();
        goto_slot(0);
        check_vec("t6_no_dispatch", bus.out, NULL_OUT);
        check_vec("t6_cnt3", 227'(bus.in_count), 227'(0));

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
